// File: rtl/spi_i2c_pkg.sv
// Shared definitions for the SPI-to-I2C command bridge: FSM encoding, status byte layout, frame sizes.
package spi_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FRAME_BITS    = 16;
  localparam int ISSUE_TIMEOUT = 16;
  localparam int CNT_W         = 6;

  localparam int STS_BUSY      = 7;
  localparam int STS_ACK_ERR   = 6;
  localparam int STS_RD_VALID  = 5;
  localparam int STS_FRAME_ERR = 4;
  localparam int STS_OVERRUN   = 3;
  localparam int STS_TMO       = 2;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift engine: input synchronizers, edge detection, saturating bit counter,
// MOSI capture and MISO serialisation of the status/read-data snapshot taken at cs_n fall.
module spi_slave_shifter
  import spi_i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [7:0]            status,
  input  logic [7:0]            rd_data,
  output logic                  frame_end,
  output logic [CNT_W-1:0]      frame_bits,
  output logic [FRAME_BITS-1:0] rx_word
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  rx_sr, tx_sr;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  // mosi uses the same depth as sclk so the sampled bit lines up with its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (!cs_s && sclk_rise) begin
      rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // First bit must be on the line before the first rising edge, so it is driven at cs_n fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_miso <= 1'b0;
      tx_sr    <= '0;
    end else if (cs_s) begin
      spi_miso <= 1'b0;
    end else if (cs_fall) begin
      spi_miso <= status[7];
      tx_sr    <= {status[6:0], rd_data, 1'b0};
    end else if (sclk_fall) begin
      spi_miso <= tx_sr[FRAME_BITS-1];
      tx_sr    <= {tx_sr[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign frame_end  = cs_rise;
  assign frame_bits = bit_cnt;
  assign rx_word    = rx_sr;

endmodule

// File: rtl/spi_i2c_ctrl.sv
// SPI slave front end that turns 16-bit frames into single-byte I2C master commands.
// Optional macro SPI_I2C_TIMEOUT_EN adds ISSUE/WAIT watchdogs and the tmo status bit.
module spi_i2c_ctrl
  import spi_i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_tx_data,
  output logic       i2c_tx_valid,
  input  logic       i2c_tx_ready,
  input  logic       i2c_busy,
  input  logic       i2c_ack_err,
  input  logic [7:0] i2c_rx_data,
  input  logic       i2c_rx_valid
);

  state_t                state_q, state_d;
  logic                  frame_end;
  logic [CNT_W-1:0]      frame_bits;
  logic [FRAME_BITS-1:0] rx_word;
  logic [7:0]            status, rd_data;
  logic                  ack_err, rd_valid, frame_err, overrun, tmo;
  logic                  len_ok, idle_free, accept, rts_clr, tmo_hit;
  logic                  unused_tx_ready;

  assign unused_tx_ready = i2c_tx_ready;

  assign len_ok    = (frame_bits == CNT_W'(FRAME_BITS));
  assign idle_free = (state_q == ST_IDLE) && !i2c_busy;
  assign accept    = frame_end && len_ok && idle_free;
  assign rts_clr   = frame_end && (frame_bits >= CNT_W'(8));

  always_comb begin
    status                = '0;
    status[STS_BUSY]      = (state_q != ST_IDLE) | i2c_busy;
    status[STS_ACK_ERR]   = ack_err;
    status[STS_RD_VALID]  = rd_valid;
    status[STS_FRAME_ERR] = frame_err;
    status[STS_OVERRUN]   = overrun;
    status[STS_TMO]       = tmo;
  end

  spi_slave_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .status     (status),
    .rd_data    (rd_data),
    .frame_end  (frame_end),
    .frame_bits (frame_bits),
    .rx_word    (rx_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (i2c_busy) state_d = ST_WAIT;
                else if (tmo_hit) state_d = ST_IDLE;
      ST_WAIT:  if (!i2c_busy) state_d = ST_DONE;
                else if (tmo_hit) state_d = ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign i2c_tx_valid = (state_q == ST_ISSUE);

  // Command fields only load on accept, so they stay frozen through ISSUE/WAIT/DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_addr    <= '0;
      i2c_rw      <= 1'b0;
      i2c_tx_data <= '0;
    end else if (accept) begin
      i2c_addr    <= rx_word[15:9];
      i2c_rw      <= rx_word[8];
      i2c_tx_data <= rx_word[7:0];
    end
  end

  // Read-to-clear happens first so a set from the same cycle takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      ack_err   <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (rts_clr) begin
        rd_valid  <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (frame_end && !len_ok) frame_err <= 1'b1;
      if (frame_end && len_ok && !idle_free) overrun <= 1'b1;
      if (state_q == ST_WAIT && i2c_rx_valid) begin
        rd_data  <= i2c_rx_data;
        rd_valid <= 1'b1;
      end
      if (state_q == ST_DONE) ack_err <= i2c_ack_err;
    end
  end

`ifdef SPI_I2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + ISSUE_TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         tmo_cnt <= '0;
    else if (state_d != state_q)                        tmo_cnt <= '0;
    else if (state_q == ST_ISSUE || state_q == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = ((state_q == ST_ISSUE) && !i2c_busy && (tmo_cnt == TW'(ISSUE_TIMEOUT - 1))) ||
                   ((state_q == ST_WAIT) && i2c_busy && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo <= 1'b0;
    else begin
      if (rts_clr) tmo <= 1'b0;
      if (tmo_hit) tmo <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_i2c_ctrl.sv
// Bench for spi_i2c_ctrl: drives SPI frames from a host task, answers I2C requests with a
// simple master model, and predicts the status/read-data bytes from the frame/transaction rules.
module tb_spi_i2c_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid, i2c_tx_ready, i2c_busy, i2c_ack_err, i2c_rx_valid;
  logic [7:0] i2c_rx_data;

  int n_cmp = 0;
  int n_err = 0;

  // I2C master model controls and observations
  int         mdl_delay = 1;
  int         mdl_hold  = 6;
  bit         mdl_nack  = 0;
  bit         mdl_nobusy = 0;
  logic [7:0] mdl_rd    = 8'h00;
  logic [6:0] cap_addr;
  logic       cap_rw;
  logic [7:0] cap_data;
  bit         stab_err, tv_after_busy;
  int         txn_done = 0;
  int         tv_rises = 0;
  int         tv_high  = 0;
  bit         tv_prev  = 0;

  // Expected status as predicted from frame/transaction history
  bit         e_ack, e_rdv, e_ferr, e_ovr, e_tmo;
  logic [7:0] e_rdd;
  logic [15:0] last_miso;

  always #5 clk = ~clk;

  spi_i2c_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .i2c_addr     (i2c_addr),
    .i2c_rw       (i2c_rw),
    .i2c_tx_data  (i2c_tx_data),
    .i2c_tx_valid (i2c_tx_valid),
    .i2c_tx_ready (i2c_tx_ready),
    .i2c_busy     (i2c_busy),
    .i2c_ack_err  (i2c_ack_err),
    .i2c_rx_data  (i2c_rx_data),
    .i2c_rx_valid (i2c_rx_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stab_chk();
    if (i2c_addr !== cap_addr || i2c_rw !== cap_rw || i2c_tx_data !== cap_data) stab_err = 1;
  endtask

  initial begin
    i2c_busy = 0; i2c_ack_err = 0; i2c_rx_valid = 0; i2c_rx_data = 0; i2c_tx_ready = 0;
    forever begin
      @(negedge clk);
      if (i2c_tx_valid && !mdl_nobusy) begin
        cap_addr = i2c_addr; cap_rw = i2c_rw; cap_data = i2c_tx_data; stab_err = 0;
        repeat (mdl_delay) begin
          @(negedge clk);
          stab_chk();
          if (!i2c_tx_valid) stab_err = 1;
        end
        i2c_busy = 1; i2c_ack_err = mdl_nack;
        @(negedge clk);
        tv_after_busy = i2c_tx_valid;
        stab_chk();
        i2c_tx_ready = !cap_rw;
        @(negedge clk);
        i2c_tx_ready = 0;
        repeat (mdl_hold) begin @(negedge clk); stab_chk(); end
        if (cap_rw && !mdl_nack) begin
          i2c_rx_data = mdl_rd; i2c_rx_valid = 1;
          @(negedge clk);
          i2c_rx_valid = 0; i2c_rx_data = $urandom_range(0, 255);
        end
        repeat (2) begin @(negedge clk); stab_chk(); end
        i2c_busy = 0;
        txn_done++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (i2c_tx_valid && !tv_prev) tv_rises++;
    if (i2c_tx_valid) tv_high++;
    tv_prev = i2c_tx_valid;
  end

  task automatic spi_frame(input int nbits, input logic [15:0] w,
                           output logic [15:0] mi, output logic tail);
    mi = '0; tail = 0;
    spi_cs_n = 0; #100;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? w[15-i] : 1'b0;
      #80;
      if (i < 16) mi[15-i] = spi_miso;
      else        tail = tail | spi_miso;
      spi_sclk = 1; #80;
      spi_sclk = 0;
    end
    #100; spi_cs_n = 1; spi_mosi = 0; #100;
  endtask

  // One host frame: check what MISO carried, then apply the frame-end status rules
  task automatic send(input int nbits, input logic [15:0] w, input bit busy_now, output bit acc);
    logic [7:0] st;
    logic [15:0] mi;
    logic tail;
    st = {busy_now, e_ack, e_rdv, e_ferr, e_ovr, e_tmo, 2'b00};
    spi_frame(nbits, w, mi, tail);
    last_miso = mi;
    if (nbits >= 8)  chk("miso_status", {8'h00, mi[15:8]}, {8'h00, st});
    if (nbits >= 16) chk("miso_rd_data", {8'h00, mi[7:0]}, {8'h00, e_rdd});
    if (nbits > 16)  chk("miso_tail_zero", {15'h0, tail}, 16'h0);
    chk("miso_idle_cs_high", {15'h0, spi_miso}, 16'h0);
    if (nbits >= 8) begin e_rdv = 0; e_ferr = 0; e_ovr = 0; e_tmo = 0; end
    acc = 0;
    if (nbits != 16)   e_ferr = 1;
    else if (busy_now) e_ovr = 1;
    else               acc = 1;
  endtask

  task automatic finish_cmd(input logic [15:0] w, input bit nack, input logic [7:0] rd,
                            input int tgt);
    for (int i = 0; i < 5000 && txn_done < tgt; i++) @(negedge clk);
    chk("txn_done", 16'(txn_done), 16'(tgt));
    repeat (4) @(negedge clk);
    chk("i2c_addr", {9'h0, cap_addr}, {9'h0, w[15:9]});
    chk("i2c_rw", {15'h0, cap_rw}, {15'h0, w[8]});
    if (!w[8]) chk("i2c_tx_data", {8'h0, cap_data}, {8'h0, w[7:0]});
    chk("cmd_stable", {15'h0, stab_err}, 16'h0);
    chk("tx_valid_low_in_wait", {15'h0, tv_after_busy}, 16'h0);
    e_ack = nack;
    if (w[8] && !nack) begin e_rdv = 1; e_rdd = rd; end
  endtask

  task automatic cmd(input logic [6:0] a, input bit rw, input logic [7:0] d,
                     input bit nack, input logic [7:0] rd);
    bit acc;
    int tgt;
    mdl_nack = nack; mdl_rd = rd; mdl_delay = $urandom_range(0, 3);
    tgt = txn_done + 1;
    send(16, {a, rw, d}, 0, acc);
    chk("frame_accepted", {15'h0, acc}, 16'h1);
    finish_cmd({a, rw, d}, nack, rd, tgt);
  endtask

  initial begin
    bit acc;
    int rises0, tgt, nb;
    logic [15:0] w1;
    rst_n = 0; spi_sclk = 0; spi_cs_n = 1; spi_mosi = 0;
    e_ack = 0; e_rdv = 0; e_ferr = 0; e_ovr = 0; e_tmo = 0; e_rdd = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_tx_valid", {15'h0, i2c_tx_valid}, 16'h0);
    chk("rst_addr", {9'h0, i2c_addr}, 16'h0);
    chk("rst_rw", {15'h0, i2c_rw}, 16'h0);
    chk("rst_tx_data", {8'h0, i2c_tx_data}, 16'h0);
    chk("rst_miso", {15'h0, spi_miso}, 16'h0);
    rst_n = 1;
    repeat (5) @(negedge clk);

    // Write 0xA0,0x5C then read 0xA1 returning 0x3E
    cmd(7'h50, 1'b0, 8'h5C, 1'b0, 8'h00);
    cmd(7'h50, 1'b1, 8'h00, 1'b0, 8'h3E);
    cmd(7'h11, 1'b0, 8'h22, 1'b0, 8'h00);
    chk("read_status_byte", {8'h0, last_miso[15:8]}, 16'h0020);
    chk("read_data_byte", {8'h0, last_miso[7:0]}, 16'h003E);
    cmd(7'h12, 1'b0, 8'h33, 1'b0, 8'h00);
    chk("rd_valid_cleared", {15'h0, last_miso[13]}, 16'h0);

    // Short 12-bit frame
    rises0 = tv_rises;
    send(12, 16'hA15C, 0, acc);
    repeat (50) @(negedge clk);
    chk("short_no_issue", 16'(tv_rises), 16'(rises0));
    cmd(7'h13, 1'b0, 8'h44, 1'b0, 8'h00);
    chk("frame_err_seen", {15'h0, last_miso[12]}, 16'h1);

    // Second frame while the first transaction keeps i2c_busy high
    mdl_hold = 600; mdl_nack = 0; mdl_delay = 1;
    w1 = {7'h2A, 1'b0, 8'hC3};
    tgt = txn_done + 1;
    rises0 = tv_rises;
    send(16, w1, 0, acc);
    for (int i = 0; i < 300 && !i2c_busy; i++) @(negedge clk);
    chk("busy_seen", {15'h0, i2c_busy}, 16'h1);
    send(16, {7'h55, 1'b0, 8'h99}, 1, acc);
    finish_cmd(w1, 1'b0, 8'h00, tgt);
    chk("overrun_single_issue", 16'(tv_rises - rises0), 16'h1);
    mdl_hold = 6;
    cmd(7'h14, 1'b0, 8'h55, 1'b0, 8'h00);
    chk("overrun_seen", {15'h0, last_miso[11]}, 16'h1);

    // Address NACK
    cmd(7'h77, 1'b0, 8'h01, 1'b1, 8'h00);
    cmd(7'h15, 1'b0, 8'h66, 1'b0, 8'h00);
    chk("ack_err_seen", {15'h0, last_miso[14]}, 16'h1);

    // Randomized mix of commands and malformed frames
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        nb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
        rises0 = tv_rises;
        send(nb, 16'($urandom), 0, acc);
        repeat (30) @(negedge clk);
        chk("bad_len_no_issue", 16'(tv_rises), 16'(rises0));
      end else begin
        cmd(7'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
            8'($urandom));
      end
    end

    // Reset in the middle of a frame
    rises0 = tv_rises;
    spi_cs_n = 0; #100;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1'($urandom); #80; spi_sclk = 1; #80; spi_sclk = 0;
    end
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("midrst_tx_valid", {15'h0, i2c_tx_valid}, 16'h0);
    chk("midrst_miso", {15'h0, spi_miso}, 16'h0);
    chk("midrst_addr", {9'h0, i2c_addr}, 16'h0);
    rst_n = 1;
    e_ack = 0; e_rdv = 0; e_ferr = 0; e_ovr = 0; e_tmo = 0; e_rdd = 8'h00;
    #100;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1'($urandom); #80; spi_sclk = 1; #80; spi_sclk = 0;
    end
    #100; spi_cs_n = 1; spi_mosi = 0; #100;
    e_ferr = 1;
    repeat (50) @(negedge clk);
    chk("midrst_no_issue", 16'(tv_rises), 16'(rises0));
    cmd(7'h16, 1'b0, 8'h77, 1'b0, 8'h00);

`ifdef SPI_I2C_TIMEOUT_EN
    // Master that never answers: ISSUE must give up after 16 cycles
    mdl_nobusy = 1;
    tv_high = 0;
    send(16, {7'h3C, 1'b0, 8'hAB}, 0, acc);
    repeat (40) @(negedge clk);
    chk("issue_timeout_len", 16'(tv_high), 16'd16);
    chk("issue_timeout_released", {15'h0, i2c_tx_valid}, 16'h0);
    e_tmo = 1;
    mdl_nobusy = 0;
    cmd(7'h17, 1'b0, 8'h88, 1'b0, 8'h00);
    chk("tmo_seen", {15'h0, last_miso[10]}, 16'h1);
`endif

    cmd(7'h18, 1'b1, 8'h00, 1'b0, 8'h5A);
    cmd(7'h19, 1'b0, 8'h99, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_i2c_ctrl.md
SPI_I2C_CTRL -- requirements
Module: spi_i2c_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3: synchronizer depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: clk cycles allowed in WAIT, used only with SPI_I2C_TIMEOUT_EN.
REQ-003 SHALL have ports clk (in, 1, system clock) and rst_n (in, 1, reset, asynchronous, active-low).
REQ-004 SHALL have SPI slave ports: spi_sclk (in, 1, SPI clock), spi_cs_n (in, 1, chip select, active-low), spi_mosi (in, 1, data from host) and spi_miso (out, 1, data to host).
REQ-005 SHALL have I2C command outputs: i2c_addr (out, 7, target address), i2c_rw (out, 1, 1 = read) and i2c_tx_data (out, 8, write byte).
REQ-006 SHALL have I2C handshake ports: i2c_tx_valid (out, 1, request), i2c_tx_ready (in, 1, write byte consumed pulse), i2c_busy (in, 1, master busy), i2c_ack_err (in, 1, NACK seen), i2c_rx_data (in, 8, read byte) and i2c_rx_valid (in, 1, read byte strobe).

Function
REQ-007 SHALL implement SPI mode 0, MSB first: sample spi_mosi on each synchronized sclk rising edge and update spi_miso on each falling edge.
REQ-008 SHALL define the frame as cs_n low to cs_n high, 16 bits: byte0 = {addr[6:0], rw}, byte1 = write data (ignored when rw = 1).
REQ-009 SHALL drive status byte {busy, ack_err, rd_valid, frame_err, overrun, tmo, 2'b00} on spi_miso during frame bits 0-7 and rd_data during bits 8-15; bits beyond 16 read 0.
REQ-010 SHALL sample both MISO bytes at cs_n falling edge; spi_miso SHALL be 0 while cs_n is high.
REQ-011 SHALL, on cs_n rising edge, accept the frame only if exactly 16 bits were received and the FSM is IDLE with i2c_busy low.
REQ-012 SHALL, for a frame of wrong length, discard it and set frame_err.
REQ-013 SHALL, for a 16-bit frame arriving while the FSM is not IDLE or i2c_busy is high, discard it and set overrun.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-015 SHALL, on frame accept, latch addr/rw/data onto the i2c_* outputs and move IDLE -> ISSUE on the next clk.
REQ-016 SHALL in ISSUE hold i2c_tx_valid high until i2c_busy is sampled high, then move to WAIT with i2c_tx_valid low.
REQ-017 SHALL hold i2c_addr, i2c_rw and i2c_tx_data stable from ISSUE entry until DONE.
REQ-018 SHALL in WAIT capture i2c_rx_data into rd_data and set rd_valid on each i2c_rx_valid.
REQ-019 SHALL leave WAIT for DONE on the first cycle i2c_busy is low.
REQ-020 SHALL in DONE copy i2c_ack_err into the ack_err status bit, then return to IDLE after 1 cycle.
REQ-021 SHALL ignore i2c_tx_ready for control purposes; it is accepted on the port and unused.
REQ-022 SHALL derive status bit busy = (FSM != IDLE) | i2c_busy.
REQ-023 SHALL clear rd_valid, frame_err, overrun and tmo (read-to-clear) at cs_n rising edge when at least 8 bits were clocked; a set caused by the same edge SHALL win.
REQ-024 SHALL treat cs_n rising mid-byte as frame end and reset the bit counter on every cs_n falling edge.

Reset
REQ-025 SHALL, while rst_n is low, force FSM = IDLE, all status bits = 0, rd_data = 0x00, i2c_addr = 0, i2c_rw = 0, i2c_tx_data = 0, i2c_tx_valid = 0, spi_miso = 0, synchronizers = cs_n 1 / sclk 0 / mosi 0 and bit counter = 0.
REQ-026 SHALL, when reset is asserted mid-frame or mid-transaction, drop the frame and not issue i2c_tx_valid after release.

Configuration
REQ-027 SHALL, with SPI_I2C_TIMEOUT_EN defined, count cycles in ISSUE and WAIT.
REQ-028 SHALL, with SPI_I2C_TIMEOUT_EN defined, set tmo and go to IDLE with i2c_tx_valid low if ISSUE exceeds 16 cycles or WAIT exceeds TIMEOUT_CYCLES.
REQ-029 SHALL, with SPI_I2C_TIMEOUT_EN undefined, have no counter, keep tmo constant 0 and make ISSUE/WAIT unbounded.

Structure
REQ-030 SHALL take FSM state encoding, status bit indices, FRAME_BITS = 16 and ISSUE_TIMEOUT = 16 from shared package spi_i2c_pkg.
REQ-031 SHALL place the SPI shift engine (synchronizers, edge detect, bit counter, MOSI/MISO shift registers) in sub-module spi_slave_shifter.

Verification
REQ-032 SHALL verify write frame 0xA0, 0x5C (addr 0x50, rw 0) -> i2c_tx_valid until busy, i2c_tx_data = 0x5C stable, DONE, status ack_err = 0.
REQ-033 SHALL verify read frame 0xA1, 0x00 with model returning 0x3E -> next frame MISO = status 0b0010_0000 then 0x3E, and a following frame shows rd_valid = 0.
REQ-034 SHALL verify a 12-bit frame -> no i2c_tx_valid, next status has frame_err = 1.
REQ-035 SHALL verify a second frame while i2c_busy is high -> discarded, overrun = 1, first transaction completes unchanged.
REQ-036 SHALL verify model NACK on address -> ack_err = 1 in next status byte.
REQ-037 SHALL verify, with SPI_I2C_TIMEOUT_EN, a model that never asserts busy -> i2c_tx_valid drops after 16 cycles and tmo = 1.
